// File: rtl/reorder_buffer_pkg.sv
// Shared widths and types for the in-order reorder buffer.
// Pointers are ROB_IDX_W wide so that they wrap on their own at ROB_SIZE.
package reorder_buffer_pkg;

    localparam int ROB_SIZE  = 16;
    localparam int ROB_IDX_W = 4;
    localparam int XLEN      = 32;
    localparam int REG_W     = 5;
    localparam int COUNT_W   = ROB_IDX_W + 1;

    typedef logic [ROB_IDX_W-1:0] rob_tag_t;
    typedef logic [COUNT_W-1:0]   rob_count_t;
    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_W-1:0]     reg_idx_t;

    localparam rob_count_t FULL_COUNT = rob_count_t'(ROB_SIZE);

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags in program order, captures CDB results and
// retires the head entry into the register file, flushing everything on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     dispatcher_en_in,
    input  reg_idx_t dispatcher_rd_in,
    input  logic     dispatcher_is_branch_in,
    output rob_tag_t dispatcher_dest_out,
    output logic     full_out,
    input  rob_tag_t query1_tag_in,
    input  rob_tag_t query2_tag_in,
    output logic     query1_ready_out,
    output logic     query2_ready_out,
    output word_t    query1_value_out,
    output word_t    query2_value_out,
    input  logic     cdb_en_in,
    input  rob_tag_t cdb_dest_in,
    input  word_t    cdb_value_in,
    input  logic     cdb_mispredict_in,
    input  word_t    cdb_target_pc_in,
    output logic     register_en_out,
    output reg_idx_t register_reg_pos_out,
    output rob_tag_t register_dest_out,
    output word_t    register_value_out,
    output logic     flush_out,
    output word_t    flush_pc_out
);

    logic [ROB_SIZE-1:0] valid;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] is_branch;
    logic [ROB_SIZE-1:0] mispredict;
    reg_idx_t            rd_q     [ROB_SIZE];
    word_t               value_q  [ROB_SIZE];
    word_t               target_q [ROB_SIZE];

    rob_tag_t   head;
    rob_tag_t   tail;
    rob_count_t count;

    logic commit;
    logic flush;
    logic cdb_hit;
    logic alloc;

    // Commit looks only at registered ready, so a CDB write to the head retires a cycle later.
    // A full buffer may still accept an allocation in a cycle that frees the head slot.
    assign commit  = valid[head] & ready[head];
    assign flush   = commit & is_branch[head] & mispredict[head];
    assign cdb_hit = cdb_en_in & valid[cdb_dest_in];
    assign alloc   = dispatcher_en_in & (!full_out | commit) & !flush;

    assign full_out            = (count == FULL_COUNT);
    assign dispatcher_dest_out = tail;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            valid                <= '0;
            ready                <= '0;
            is_branch            <= '0;
            mispredict           <= '0;
            register_en_out      <= 1'b0;
            register_reg_pos_out <= '0;
            register_dest_out    <= '0;
            register_value_out   <= '0;
            flush_out            <= 1'b0;
            flush_pc_out         <= '0;
        end else if (rdy_in) begin
            register_en_out <= 1'b0;
            flush_out       <= 1'b0;
            if (commit) begin
                register_en_out      <= (rd_q[head] != '0);
                register_reg_pos_out <= rd_q[head];
                register_dest_out    <= head;
                register_value_out   <= value_q[head];
                valid[head]          <= 1'b0;
            end
            if (cdb_hit) begin
                ready[cdb_dest_in]      <= 1'b1;
                mispredict[cdb_dest_in] <= cdb_mispredict_in;
            end
            // Allocation comes last so it wins over a commit freeing the same slot.
            if (alloc) begin
                valid[tail]      <= 1'b1;
                ready[tail]      <= 1'b0;
                is_branch[tail]  <= dispatcher_is_branch_in;
                mispredict[tail] <= 1'b0;
            end
            if (flush) begin
                flush_out    <= 1'b1;
                flush_pc_out <= target_q[head];
                valid        <= '0;
                head         <= '0;
                tail         <= '0;
                count        <= '0;
            end else begin
                if (commit) head <= head + rob_tag_t'(1);
                if (alloc)  tail <= tail + rob_tag_t'(1);
                case ({alloc, commit})
                    2'b10:   count <= count + rob_count_t'(1);
                    2'b01:   count <= count - rob_count_t'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: payload arrays carry no reset; valid/ready gate every use, so stale data is never seen.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (cdb_hit) begin
                value_q[cdb_dest_in]  <= cdb_value_in;
                target_q[cdb_dest_in] <= cdb_target_pc_in;
            end
            if (alloc) rd_q[tail] <= dispatcher_rd_in;
        end
    end

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        query1_ready_out = valid[query1_tag_in] & ready[query1_tag_in];
        query1_value_out = value_q[query1_tag_in];
        query2_ready_out = valid[query2_tag_in] & ready[query2_tag_in];
        query2_value_out = value_q[query2_tag_in];
        if (cdb_hit && cdb_dest_in == query1_tag_in) begin
            query1_ready_out = 1'b1;
            query1_value_out = cdb_value_in;
        end
        if (cdb_hit && cdb_dest_in == query2_tag_in) begin
            query2_ready_out = 1'b1;
            query2_value_out = cdb_value_in;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a cycle table for the basic flow, then scoreboarded
// sequences for fill/wrap, rdy freeze, mispredict flush, rd=0 retire and mid-stream reset.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic     clk_in = 1'b0;
    logic     rst_in, rdy_in;
    logic     dispatcher_en_in, dispatcher_is_branch_in;
    reg_idx_t dispatcher_rd_in;
    rob_tag_t dispatcher_dest_out;
    logic     full_out;
    rob_tag_t query1_tag_in, query2_tag_in;
    logic     query1_ready_out, query2_ready_out;
    word_t    query1_value_out, query2_value_out;
    logic     cdb_en_in, cdb_mispredict_in;
    rob_tag_t cdb_dest_in;
    word_t    cdb_value_in, cdb_target_pc_in;
    logic     register_en_out, flush_out;
    reg_idx_t register_reg_pos_out;
    rob_tag_t register_dest_out;
    word_t    register_value_out, flush_pc_out;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dispatcher_en_in(dispatcher_en_in), .dispatcher_rd_in(dispatcher_rd_in),
        .dispatcher_is_branch_in(dispatcher_is_branch_in),
        .dispatcher_dest_out(dispatcher_dest_out), .full_out(full_out),
        .query1_tag_in(query1_tag_in), .query2_tag_in(query2_tag_in),
        .query1_ready_out(query1_ready_out), .query2_ready_out(query2_ready_out),
        .query1_value_out(query1_value_out), .query2_value_out(query2_value_out),
        .cdb_en_in(cdb_en_in), .cdb_dest_in(cdb_dest_in), .cdb_value_in(cdb_value_in),
        .cdb_mispredict_in(cdb_mispredict_in), .cdb_target_pc_in(cdb_target_pc_in),
        .register_en_out(register_en_out), .register_reg_pos_out(register_reg_pos_out),
        .register_dest_out(register_dest_out), .register_value_out(register_value_out),
        .flush_out(flush_out), .flush_pc_out(flush_pc_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic     den;  reg_idx_t rd;
        logic     cen;  rob_tag_t ctag; word_t cval;
        rob_tag_t qtag; logic eqrdy; word_t eqval;
        rob_tag_t edest; logic efull;
        logic     een;  reg_idx_t epos; rob_tag_t etag; word_t eval;
    } vec_t;

    typedef struct {
        reg_idx_t rd;
        rob_tag_t tag;
        word_t    value;
    } sb_entry_t;

    vec_t      tbl [10];
    sb_entry_t exp_q [$];
    sb_entry_t e_mon;
    word_t     plan [ROB_SIZE];
    rob_tag_t  tb_tail;
    int        n_total = 0;
    int        n_pass  = 0;
    logic      sb_on = 1'b0;
    logic      rdy_s, rst_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        dispatcher_en_in = 1'b0; dispatcher_rd_in = '0; dispatcher_is_branch_in = 1'b0;
        cdb_en_in = 1'b0; cdb_dest_in = '0; cdb_value_in = '0;
        cdb_mispredict_in = 1'b0; cdb_target_pc_in = '0;
    endtask

    // Allocate one entry; the planned result is recorded so a later CDB write can use it.
    task automatic alloc(input reg_idx_t rd, input logic br, input word_t val, input logic push);
        dispatcher_en_in = 1'b1; dispatcher_rd_in = rd; dispatcher_is_branch_in = br;
        plan[tb_tail] = val;
        if (push && rd != '0) exp_q.push_back('{rd, tb_tail, val});
        tb_tail = tb_tail + rob_tag_t'(1);
        tick();
        idle();
    endtask

    task automatic cdb(input rob_tag_t tag);
        cdb_en_in = 1'b1; cdb_dest_in = tag; cdb_value_in = plan[tag];
        tick();
        idle();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    // Commit monitor: every visible commit must match the oldest outstanding expectation.
    always begin
        @(posedge clk_in);
        rdy_s = rdy_in;
        rst_s = rst_in;
        #1;
        if (sb_on && rdy_s && !rst_s && register_en_out) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: commit of tag %0d, expected no commit", register_dest_out);
            end else begin
                e_mon = exp_q.pop_front();
                check("sb_pos",   register_reg_pos_out, e_mon.rd);
                check("sb_tag",   register_dest_out,    e_mon.tag);
                check("sb_value", register_value_out,   e_mon.value);
            end
        end
    end

    initial begin
        //            den  rd    cen  ctag   cval          qtag eqrdy eqval          edst efl  een  epos  etag  eval
        tbl[0] = '{1'b1, 5'd1, 1'b0, 4'd0, 32'h0,      4'd0, 1'b0, 32'h0,      4'd1, 1'b0, 1'b0, 5'd0, 4'd0, 32'h0};
        tbl[1] = '{1'b1, 5'd2, 1'b0, 4'd0, 32'h0,      4'd0, 1'b0, 32'h0,      4'd2, 1'b0, 1'b0, 5'd0, 4'd0, 32'h0};
        tbl[2] = '{1'b1, 5'd3, 1'b0, 4'd0, 32'h0,      4'd0, 1'b0, 32'h0,      4'd3, 1'b0, 1'b0, 5'd0, 4'd0, 32'h0};
        tbl[3] = '{1'b0, 5'd0, 1'b1, 4'd1, 32'h11,     4'd1, 1'b1, 32'h11,     4'd3, 1'b0, 1'b0, 5'd0, 4'd0, 32'h0};
        tbl[4] = '{1'b0, 5'd0, 1'b1, 4'd0, 32'h22,     4'd1, 1'b1, 32'h11,     4'd3, 1'b0, 1'b0, 5'd0, 4'd0, 32'h0};
        tbl[5] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,      4'd0, 1'b1, 32'h22,     4'd3, 1'b0, 1'b1, 5'd1, 4'd0, 32'h22};
        tbl[6] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,      4'd2, 1'b0, 32'h0,      4'd3, 1'b0, 1'b1, 5'd2, 4'd1, 32'h11};
        tbl[7] = '{1'b0, 5'd0, 1'b1, 4'd2, 32'hABCD,   4'd2, 1'b1, 32'hABCD,   4'd3, 1'b0, 1'b0, 5'd0, 4'd0, 32'h0};
        tbl[8] = '{1'b0, 5'd0, 1'b1, 4'd9, 32'h99,     4'd9, 1'b0, 32'h0,      4'd3, 1'b0, 1'b1, 5'd3, 4'd2, 32'hABCD};
        tbl[9] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,      4'd2, 1'b0, 32'h0,      4'd3, 1'b0, 1'b0, 5'd0, 4'd0, 32'h0};

        rst_in = 1'b1; rdy_in = 1'b1; query1_tag_in = '0; query2_tag_in = '0;
        idle();
        tick(); tick();
        rst_in = 1'b0;
        check("rst_reg_en",  register_en_out,     0);
        check("rst_flush",   flush_out,           0);
        check("rst_reg_val", register_value_out,  0);
        check("rst_flush_pc", flush_pc_out,       0);
        check("rst_dest",    dispatcher_dest_out, 0);
        check("rst_full",    full_out,            0);

        for (int i = 0; i < 10; i++) begin
            dispatcher_en_in = tbl[i].den; dispatcher_rd_in = tbl[i].rd;
            cdb_en_in = tbl[i].cen; cdb_dest_in = tbl[i].ctag; cdb_value_in = tbl[i].cval;
            query1_tag_in = tbl[i].qtag; query2_tag_in = tbl[i].qtag;
            #1;
            check($sformatf("v%0d_q1_ready", i), query1_ready_out, tbl[i].eqrdy);
            check($sformatf("v%0d_q2_ready", i), query2_ready_out, tbl[i].eqrdy);
            if (tbl[i].eqrdy) begin
                check($sformatf("v%0d_q1_value", i), query1_value_out, tbl[i].eqval);
                check($sformatf("v%0d_q2_value", i), query2_value_out, tbl[i].eqval);
            end
            tick();
            check($sformatf("v%0d_dest", i),   dispatcher_dest_out, tbl[i].edest);
            check($sformatf("v%0d_full", i),   full_out,            tbl[i].efull);
            check($sformatf("v%0d_reg_en", i), register_en_out,     tbl[i].een);
            if (tbl[i].een) begin
                check($sformatf("v%0d_reg_pos", i), register_reg_pos_out, tbl[i].epos);
                check($sformatf("v%0d_reg_tag", i), register_dest_out,    tbl[i].etag);
                check($sformatf("v%0d_reg_val", i), register_value_out,   tbl[i].eval);
            end
        end
        idle();

        // Fill, overflow attempt, then commit+alloc together while full.
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        tb_tail = '0; sb_on = 1'b1;
        for (int i = 0; i < ROB_SIZE; i++) alloc(reg_idx_t'(i + 1), 1'b0, 32'h100 + i, 1'b1);
        check("fill_full", full_out, 1);
        check("fill_dest", dispatcher_dest_out, tb_tail);
        dispatcher_en_in = 1'b1; dispatcher_rd_in = 5'd9;
        tick(); idle();
        check("over_full", full_out, 1);
        check("over_dest", dispatcher_dest_out, 0);
        cdb(4'd0);
        alloc(5'd17, 1'b0, 32'h200, 1'b1);
        check("wrap_full", full_out, 1);
        check("wrap_dest", dispatcher_dest_out, 1);
        cdb(4'd0);
        for (int t = ROB_SIZE - 1; t >= 1; t--) cdb(rob_tag_t'(t));
        drain("fill_drain");

        // rdy_in freeze in the middle of a stream of commits.
        alloc(5'd10, 1'b0, 32'h300, 1'b1);
        alloc(5'd11, 1'b0, 32'h301, 1'b1);
        alloc(5'd12, 1'b0, 32'h302, 1'b1);
        cdb(4'd1);
        cdb(4'd2);
        rdy_in = 1'b0; dispatcher_en_in = 1'b1; dispatcher_rd_in = 5'd13;
        cdb_en_in = 1'b1; cdb_dest_in = 4'd3; cdb_value_in = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz%0d_reg_en", i),  register_en_out,     1);
            check($sformatf("frz%0d_reg_tag", i), register_dest_out,   1);
            check($sformatf("frz%0d_dest", i),    dispatcher_dest_out, tb_tail);
        end
        rdy_in = 1'b1; idle();
        tick();
        check("resume_tag", register_dest_out, 2);
        cdb(4'd3);
        drain("frz_drain");

        // Mispredicted branch at the head flushes everything, dropping a same-cycle alloc.
        alloc(5'd5, 1'b1, 32'h44, 1'b1);
        alloc(5'd6, 1'b0, 32'h45, 1'b0);
        alloc(5'd7, 1'b0, 32'h46, 1'b0);
        cdb(4'd5);
        cdb_en_in = 1'b1; cdb_dest_in = 4'd4; cdb_value_in = 32'h44;
        cdb_mispredict_in = 1'b1; cdb_target_pc_in = 32'h1000;
        tick(); idle();
        dispatcher_en_in = 1'b1; dispatcher_rd_in = 5'd8;
        tick(); idle();
        check("fl_flush",    flush_out,            1);
        check("fl_pc",       flush_pc_out,         32'h1000);
        check("fl_reg_en",   register_en_out,      1);
        check("fl_reg_pos",  register_reg_pos_out, 5);
        check("fl_dest",     dispatcher_dest_out,  0);
        check("fl_full",     full_out,             0);
        query1_tag_in = 4'd5;
        #1;
        check("fl_q_invalid", query1_ready_out, 0);
        tick();
        check("fl_flush_off", flush_out,       0);
        check("fl_reg_off",   register_en_out, 0);
        tb_tail = '0;

        // rd = 0 retires without a register write.
        alloc(5'd0, 1'b0, 32'h55, 1'b0);
        cdb(4'd0);
        tick();
        check("rd0_reg_en",  register_en_out,    0);
        check("rd0_tag",     register_dest_out,  0);
        check("rd0_value",   register_value_out, 32'h55);
        check("rd0_dest",    dispatcher_dest_out, 1);

        // Reset with live entries empties the buffer at once.
        alloc(5'd3, 1'b0, 32'h61, 1'b1);
        alloc(5'd4, 1'b0, 32'h62, 1'b1);
        cdb(4'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0; exp_q.delete(); tb_tail = '0;
        query1_tag_in = 4'd1;
        #1;
        check("mrst_dest",    dispatcher_dest_out, 0);
        check("mrst_full",    full_out,            0);
        check("mrst_reg_en",  register_en_out,     0);
        check("mrst_reg_val", register_value_out,  0);
        check("mrst_q_ready", query1_ready_out,    0);
        tick();
        check("mrst_no_commit", register_en_out, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
